// File: rtl/forth_pkg.sv
// Shared constants and types for the forth core instruction-side loader.
package forth_pkg;

    localparam logic [7:0] LOADER_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StCsum,
        StRun,
        StErr
    } loader_state_t;

endpackage

// File: rtl/forth_imem.sv
// 1R1W synchronous instruction RAM; a same-address collision returns the old word.
module forth_imem #(
    parameter int unsigned iaddr_width = 10,
    parameter int unsigned instr_width = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [iaddr_width-1:0] waddr,
    input  logic [instr_width-1:0] wdata,
    input  logic [iaddr_width-1:0] raddr,
    output logic [instr_width-1:0] rdata
);

    logic [instr_width-1:0] mem [2**iaddr_width];

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/forth_loader.sv
// Framed, checksummed byte-stream program loader; holds the core in reset until a good load.
module forth_loader
    import forth_pkg::*;
#(
    parameter int unsigned iaddr_width = 10,
    parameter int unsigned instr_width = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   reload,
    input  logic [iaddr_width-1:0] iaddr,
    output logic [instr_width-1:0] idata,
    output logic                   core_reset,
    output logic                   load_done,
    output logic                   load_error
);

    localparam int unsigned CntW   = iaddr_width + 1;
    localparam logic [16:0] MaxLen = 17'(2 ** iaddr_width);

    loader_state_t   state_q, state_d;
    logic [CntW-1:0] counter_q, counter_d;
    logic [CntW-1:0] len_q, len_d;
    logic [7:0]      csum_q, csum_d;
    logic [7:0]      hi_q, hi_d;
    logic [7:0]      len_hi_q, len_hi_d;
    logic            rx_ready_q, core_reset_q, load_done_q, load_error_q;

    logic            accept;
    logic            we;
    logic [15:0]     len_word;
    logic [CntW-1:0] counter_inc;

    assign accept      = rx_valid && rx_ready_q;
    assign len_word    = {len_hi_q, rx_data};
    assign counter_inc = counter_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        len_d     = len_q;
        csum_d    = csum_q;
        hi_d      = hi_q;
        len_hi_d  = len_hi_q;
        we        = 1'b0;
        unique case (state_q)
            StIdle, StErr: begin
                if (accept && rx_data == LOADER_MAGIC) begin
                    state_d = StLenHi;
                    csum_d  = 8'h00;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_hi_d = rx_data;
                    csum_d   = csum_q ^ rx_data;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    if ({1'b0, len_word} > MaxLen) begin
                        state_d = StErr;
                    end else if (len_word == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        counter_d = '0;
                        len_d     = len_word[CntW-1:0];
                        state_d   = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (accept) begin
                    hi_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = StDataLo;
                end
            end
            StDataLo: begin
                if (accept) begin
                    we        = 1'b1;
                    csum_d    = csum_q ^ rx_data;
                    counter_d = counter_inc;
                    state_d   = (counter_inc == len_q) ? StCsum : StDataHi;
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? StRun : StErr;
                end
            end
            StRun: begin
                if (reload) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status flags decode the next state so they change on the same edge as state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            counter_q    <= '0;
            len_q        <= '0;
            csum_q       <= 8'h00;
            hi_q         <= 8'h00;
            len_hi_q     <= 8'h00;
            rx_ready_q   <= 1'b0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            len_q        <= len_d;
            csum_q       <= csum_d;
            hi_q         <= hi_d;
            len_hi_q     <= len_hi_d;
            rx_ready_q   <= (state_d != StRun);
            core_reset_q <= (state_d != StRun);
            load_done_q  <= (state_d == StRun);
            load_error_q <= (state_d == StErr);
        end
    end

    assign rx_ready   = rx_ready_q;
    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

    forth_imem #(
        .iaddr_width(iaddr_width),
        .instr_width(instr_width)
    ) u_imem (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .waddr(counter_q[iaddr_width-1:0]),
        .wdata({hi_q, rx_data}),
        .raddr(iaddr),
        .rdata(idata)
    );

endmodule

// File: tb/tb_forth_loader.sv
// Bench for forth_loader: frame driver, RAM model and read scoreboard.
module tb_forth_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        reload;
    logic [9:0]  iaddr;
    logic [15:0] idata;
    logic        core_reset;
    logic        load_done;
    logic        load_error;

    int total = 0;
    int bad   = 0;

    logic [15:0] model [1024];
    logic [15:0] payload [$];
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];
    logic [15:0] e, o;
    logic [3:0]  st;

    always #5 clk = ~clk;

    forth_loader #(
        .iaddr_width(10),
        .instr_width(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .reload    (reload),
        .iaddr     (iaddr),
        .idata     (idata),
        .core_reset(core_reset),
        .load_done (load_done),
        .load_error(load_error)
    );

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (!rx_ready) begin
            bad++;
            $display("FAIL send_byte_timeout: rx_ready=%b required 1 for byte %h", rx_ready, b);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Sends a frame built from payload; RAM model tracks every word written.
    task automatic send_frame(input logic [15:0] len, input logic [7:0] corrupt, input bit gap);
        logic [7:0] cs;
        cs = len[15:8] ^ len[7:0];
        send_byte(8'hA5, gap);
        send_byte(len[15:8], gap);
        send_byte(len[7:0], gap);
        for (int i = 0; i < int'(len); i++) begin
            send_byte(payload[i][15:8], gap);
            send_byte(payload[i][7:0], gap);
            cs = cs ^ payload[i][15:8] ^ payload[i][7:0];
            model[i] = payload[i];
        end
        send_byte(cs ^ corrupt, gap);
    endtask

    task automatic issue_read(input int a);
        iaddr = 10'(a);
        exp_q.push_back(model[a]);
        @(posedge clk);
        #1;
        obs_q.push_back(idata);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        iaddr    = '0;
        repeat (3) @(posedge clk);
        #1;
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b1000) begin
            bad++;
            $display("FAIL reset_status: got %b required 1000", st);
        end
        total++;
        if (idata !== 16'h0000) begin
            bad++;
            $display("FAIL reset_idata: got %h required 0000", idata);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b1001) begin
            bad++;
            $display("FAIL reset_release_idle: got %b required 1001", st);
        end
    endtask

    task automatic test_good_load();
        payload = '{16'h1234, 16'h5678, 16'h9ABC};
        send_frame(16'd3, 8'h00, 1'b0);
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b0100) begin
            bad++;
            $display("FAIL good_load_status: got %b required 0100", st);
        end
        issue_read(1);
        issue_read(2);
        issue_read(0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL good_load_read: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_bad_csum();
        pulse_reload();
        payload = '{16'h1234, 16'h5678, 16'h9ABC};
        send_frame(16'd3, 8'h03, 1'b0);
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b1011) begin
            bad++;
            $display("FAIL bad_csum_status: got %b required 1011", st);
        end
        payload = '{16'hABCD};
        send_frame(16'd1, 8'h00, 1'b0);
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b0100) begin
            bad++;
            $display("FAIL bad_csum_recover: got %b required 0100", st);
        end
        issue_read(0);
        issue_read(1);
        issue_read(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL partial_overwrite_read: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_oversize();
        pulse_reload();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h01, 1'b0);
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b1011) begin
            bad++;
            $display("FAIL oversize_err: got %b required 1011", st);
        end
        payload.delete();
        for (int i = 0; i < 1024; i++) payload.push_back(16'(i * 40503 + 4660));
        send_frame(16'h0400, 8'h00, 1'b0);
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b0100) begin
            bad++;
            $display("FAIL full_depth_status: got %b required 0100", st);
        end
        issue_read(0);
        issue_read(511);
        issue_read(1023);
        issue_read(int'($urandom_range(1, 1022)));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL full_depth_read: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_zero_len_noise();
        pulse_reload();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b1001) begin
            bad++;
            $display("FAIL noise_stays_idle: got %b required 1001", st);
        end
        payload.delete();
        send_frame(16'd0, 8'h00, 1'b1);
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b0100) begin
            bad++;
            $display("FAIL zero_len_status: got %b required 0100", st);
        end
        // Bytes presented while running must not disturb anything.
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b0100) begin
            bad++;
            $display("FAIL run_ignores_rx: got %b required 0100", st);
        end
        issue_read(0);
        issue_read(1023);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL zero_len_ram_kept: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        pulse_reload();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        model[0] = 16'h1122;
        reset = 1'b1;
        @(posedge clk);
        #1;
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b1000) begin
            bad++;
            $display("FAIL mid_frame_reset_status: got %b required 1000", st);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b1001) begin
            bad++;
            $display("FAIL mid_frame_idle: got %b required 1001", st);
        end
        issue_read(0);
        issue_read(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL mid_frame_ram_kept: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_reload();
        payload = '{16'h0007};
        send_frame(16'd1, 8'h00, 1'b0);
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b0100) begin
            bad++;
            $display("FAIL reload_first_run: got %b required 0100", st);
        end
        pulse_reload();
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b1001) begin
            bad++;
            $display("FAIL reload_to_idle: got %b required 1001", st);
        end
        payload = '{16'hDEAD, 16'hBEEF};
        send_frame(16'd2, 8'h00, 1'b1);
        st = {core_reset, load_done, load_error, rx_ready};
        total++;
        if (st !== 4'b0100) begin
            bad++;
            $display("FAIL reload_second_run: got %b required 0100", st);
        end
        issue_read(0);
        issue_read(1);
        issue_read(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reload_read: got %h required %h", o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_csum();
        test_oversize();
        test_zero_len_noise();
        test_reset_mid_frame();
        test_reload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
